// File: rtl/mc_alu_flops_pkg.sv
// Shared definitions for the execute-stage primitives.
// The package holds the ALU opcode constants and the result-select encoding
// carried by alucontrol[1:0].
package mc_alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1111;

  // Result select held in alucontrol[1:0]
  typedef enum logic [1:0] {
    SEL_AND = 2'b00,
    SEL_OR  = 2'b01,
    SEL_SUM = 2'b10,
    SEL_SLT = 2'b11
  } alu_sel_e;

endpackage

// File: rtl/mc_alu_flops_if.sv
// Bus bundle for mc_alu_flops.
// Signals:
//   a, b, alucontrol  ALU operands and operation select
//   aluresult, zero   combinational ALU result and zero flag
//   aluout            registered ALU result (ALUOut)
//   en, d, q          enabled register load enable, data in, data out
// The master modport drives the inputs; the slave modport is the design side.
interface mc_alu_flops_if #(parameter int WIDTH = 32);
  logic [31:0]      a;
  logic [31:0]      b;
  logic [3:0]       alucontrol;
  logic [31:0]      aluresult;
  logic             zero;
  logic [31:0]      aluout;
  logic             en;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;

  modport master (
    output a, b, alucontrol, en, d,
    input  aluresult, zero, aluout, q
  );

  modport slave (
    input  a, b, alucontrol, en, d,
    output aluresult, zero, aluout, q
  );
endinterface

// File: rtl/mc_alu_flops_prims.sv
// Execute-stage primitives, each usable on its own by the datapath.
//   alu      32-bit combinational ALU
//            a, b: operands; alucontrol: op select; result, zero: outputs
//   flopr    resettable register, loads d every rising edge
//   flopenr  resettable register, loads d on a rising edge when en=1
// Both registers clear asynchronously on an active-high reset.
module alu
  import mc_alu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  alucontrol,
  output logic [31:0] result,
  output logic        zero
);
  logic [31:0] bb;
  logic [32:0] sum;
  logic        ovf;
  logic        lt;

  // Bit 2 turns the adder into a subtractor: a + ~b + 1.
  assign bb  = alucontrol[2] ? ~b : b;
  assign sum = {1'b0, a} + {1'b0, bb} + 33'(alucontrol[2]);

  // Signed compare stays correct when the subtraction overflows.
  assign ovf = (a[31] == bb[31]) & (sum[31] != a[31]);

  // Bit 3 only matters for the compare: unsigned less-than is a missing carry.
  assign lt  = alucontrol[3] ? ~sum[32] : (sum[31] ^ ovf);

  always_comb begin
    result = '0;
    unique case (alu_sel_e'(alucontrol[1:0]))
      SEL_AND: result = a & bb;
      SEL_OR:  result = a | bb;
      SEL_SUM: result = sum[31:0];
      SEL_SLT: result = {31'b0, lt};
      default: result = '0;
    endcase
  end

  assign zero = (result == 32'd0);
endmodule

module flopr #(parameter int WIDTH = 32) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or posedge reset)
    if (reset) q <= '0;
    else       q <= d;
endmodule

module flopenr #(parameter int WIDTH = 32) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or posedge reset)
    if (reset)   q <= '0;
    else if (en) q <= d;
endmodule

// File: rtl/mc_alu_flops.sv
// Wrapper exposing the execute-stage primitives together.
//   clk    rising-edge clock
//   reset  asynchronous active-high clear of both registers
//   bus    slave side of mc_alu_flops_if (ALU operands/results, ALUOut,
//          enabled-register en/d/q)
// ALU feeds the ALUOut register; the enabled register is wired independently.
module mc_alu_flops #(parameter int WIDTH = 32) (
  input logic           clk,
  input logic           reset,
  mc_alu_flops_if.slave bus
);
  alu u_alu (
    .a          (bus.a),
    .b          (bus.b),
    .alucontrol (bus.alucontrol),
    .result     (bus.aluresult),
    .zero       (bus.zero)
  );

  flopr #(.WIDTH(32)) u_aluout (
    .clk   (clk),
    .reset (reset),
    .d     (bus.aluresult),
    .q     (bus.aluout)
  );

  flopenr #(.WIDTH(WIDTH)) u_enreg (
    .clk   (clk),
    .reset (reset),
    .en    (bus.en),
    .d     (bus.d),
    .q     (bus.q)
  );
endmodule

// File: tb/tb_mc_alu_flops.sv
module tb_mc_alu_flops;
  import mc_alu_pkg::*;

  localparam int WIDTH = 32;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  mc_alu_flops_if #(.WIDTH(WIDTH)) bus ();

  mc_alu_flops #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  ctl;
    logic [31:0] res;
    logic        zero;
  } vec_t;

  vec_t        vecs[10];
  logic [3:0]  ops[10];

  // Reference from the arithmetic meaning of each opcode.
  function automatic logic [31:0] ref_alu(logic [31:0] a, logic [31:0] b, logic [3:0] c);
    logic [31:0] r;
    r = '0;
    case (c)
      ALU_AND, 4'b1000: r = a & b;
      ALU_OR,  4'b1001: r = a | b;
      ALU_ADD, 4'b1010: r = a + b;
      ALU_SUB, 4'b1110: r = a - b;
      ALU_SLT:          r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU:         r = (a < b) ? 32'd1 : 32'd0;
      default:          r = '0;
    endcase
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  initial begin
    logic [31:0] er;
    logic [31:0] qm;

    total = 0;
    bad   = 0;

    vecs[0] = '{"add_ovf",  32'h7FFFFFFF, 32'h00000001, ALU_ADD,  32'h80000000, 1'b0};
    vecs[1] = '{"add_wrap", 32'hFFFFFFFF, 32'h00000001, ALU_ADD,  32'h00000000, 1'b1};
    vecs[2] = '{"sub_zero", 32'd5,        32'd5,        ALU_SUB,  32'h00000000, 1'b1};
    vecs[3] = '{"slt_neg",  32'hFFFFFFFF, 32'h00000001, ALU_SLT,  32'h00000001, 1'b0};
    vecs[4] = '{"sltu_big", 32'hFFFFFFFF, 32'h00000001, ALU_SLTU, 32'h00000000, 1'b1};
    vecs[5] = '{"slt_ovf",  32'h80000000, 32'h7FFFFFFF, ALU_SLT,  32'h00000001, 1'b0};
    vecs[6] = '{"and",      32'hF0F0F0F0, 32'h0FF00FF0, ALU_AND,  32'h00F000F0, 1'b0};
    vecs[7] = '{"or",       32'hF0F0F0F0, 32'h0FF00FF0, ALU_OR,   32'hFFF0FFF0, 1'b0};
    vecs[8] = '{"sub_neg",  32'd3,        32'd7,        ALU_SUB,  32'hFFFFFFFC, 1'b0};
    vecs[9] = '{"sub_alias",32'd10,       32'd4,        4'b1110,  32'h00000006, 1'b0};

    ops = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_SLTU,
            4'b1000, 4'b1001, 4'b1010, 4'b1110};

    reset = 1'b1;
    bus.a = '0; bus.b = '0; bus.alucontrol = ALU_AND; bus.en = 1'b0; bus.d = '0;
    #12;
    chk("reset_aluout", bus.aluout, 32'd0);
    chk("reset_q", bus.q, 32'd0);
    @(negedge clk) reset = 1'b0;

    foreach (vecs[i]) begin
      bus.a = vecs[i].a; bus.b = vecs[i].b; bus.alucontrol = vecs[i].ctl;
      #1;
      chk({vecs[i].name, "_res"}, bus.aluresult, vecs[i].res);
      chk({vecs[i].name, "_zero"}, {31'b0, bus.zero}, {31'b0, vecs[i].zero});
    end

    // ALUOut latency
    @(negedge clk);
    bus.a = 32'd1; bus.b = 32'd2; bus.alucontrol = ALU_ADD;
    @(posedge clk) #1;
    chk("aluout_first", bus.aluout, 32'd3);
    #1 bus.a = 32'd10; bus.b = 32'd20;
    #1 chk("aluout_hold", bus.aluout, 32'd3);
    @(posedge clk) #1;
    chk("aluout_next", bus.aluout, 32'd30);

    // Enabled register
    @(negedge clk) bus.en = 1'b0; bus.d = 32'h00400000;
    @(posedge clk) #1 chk("q_en0", bus.q, 32'd0);
    @(negedge clk) bus.en = 1'b1;
    @(posedge clk) #1 chk("q_load", bus.q, 32'h00400000);
    @(negedge clk) bus.en = 1'b0; bus.d = 32'h00001234;
    @(posedge clk) #1 chk("q_hold", bus.q, 32'h00400000);

    // Async reset pulse between edges
    @(negedge clk) #1 reset = 1'b1;
    #1;
    chk("async_aluout", bus.aluout, 32'd0);
    chk("async_q", bus.q, 32'd0);
    #1 reset = 1'b0;
    @(posedge clk) #1;
    chk("post_pulse_aluout", bus.aluout, 32'd30);
    chk("post_pulse_q", bus.q, 32'd0);

    // Reset held across an edge with en=1
    @(negedge clk) reset = 1'b1; bus.en = 1'b1; bus.d = 32'h00000ABC;
    @(posedge clk) #1;
    chk("held_q", bus.q, 32'd0);
    chk("held_aluout", bus.aluout, 32'd0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk) #1 chk("first_load_q", bus.q, 32'h00000ABC);

    // Randomized traffic against the reference
    qm = 32'h00000ABC;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      bus.a = $urandom;
      bus.b = ($urandom_range(0, 3) == 0) ? bus.a : $urandom;
      bus.alucontrol = ops[$urandom_range(0, 9)];
      bus.en = 1'($urandom_range(0, 1));
      bus.d = $urandom;
      er = ref_alu(bus.a, bus.b, bus.alucontrol);
      #1;
      chk("rnd_res", bus.aluresult, er);
      chk("rnd_zero", {31'b0, bus.zero}, {31'b0, (er == 32'd0)});
      if (bus.en) qm = bus.d;
      @(posedge clk) #1;
      chk("rnd_aluout", bus.aluout, er);
      chk("rnd_q", bus.q, qm);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mc_alu_flops.md
# mc_alu_flops

Execute-stage primitive bundle for the multi-cycle MIPS datapath: a 32-bit combinational ALU (`alu`), a plain resettable register (`flopr`) capturing the ALU result as ALUOut, and an enable-gated resettable register (`flopenr`) of the kind used for the PC and the instruction register. The wrapper exposes all three so the sub-modules can be verified together and reused individually by the datapath.

## Interface
- `WIDTH`, default 32: width of the `flopenr` data path (`d`/`q`). The ALU and ALUOut register are fixed at 32 bits.
- `clk`  in  1  clock; all registers update on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all registers.
- `a`  in  32  ALU operand A (SrcA).
- `b`  in  32  ALU operand B (SrcB).
- `alucontrol`  in  4  ALU operation select.
- `aluresult`  out  32  combinational ALU result.
- `zero`  out  1  high when `aluresult == 0`.
- `aluout`  out  32  `aluresult` registered every cycle (ALUOut).
- `en`  in  1  load enable for the enabled register.
- `d`  in  WIDTH  enabled-register data input.
- `q`  out  WIDTH  enabled-register output.

## Operation
- `bb = alucontrol[2] ? ~b : b`; `sum = a + bb + alucontrol[2]`, computed at 33 bits (carry-out kept).
- `alucontrol[1:0]` selects the result:
  - `00`: `a & bb`
  - `01`: `a | bb`
  - `10`: `sum[31:0]`
  - `11`: set-less-than
- Required codes: `0000` AND, `0001` OR, `0010` ADD, `0110` SUB, `0111` SLT, `1111` SLTU.
- SLT (`alucontrol[3]=0`, `[1:0]=11`): result is `{31'b0, lt}`, where `lt = sum[31] ^ ovf` and `ovf = (a[31] == bb[31]) & (sum[31] != a[31])`. This is a true signed compare, correct on overflow.
- SLTU (`alucontrol[3]=1`, `[1:0]=11`): `lt = ~carry_out` of `a + ~b + 1`, i.e. unsigned `a < b`.
- `alucontrol[3]` has no effect on any other code. For example, `1010` behaves as ADD and `1110` as SUB.
- Arithmetic wraps modulo 2^32. No overflow flag is exported.
- `zero` is derived from the final `aluresult`. The controller also uses `aluresult[31]` after SUB for less-or-equal branching, so SUB must output the raw 32-bit difference.
- `flopr`: `aluout <= aluresult` every cycle.
- `flopenr`: `q <= d` only when `en = 1`; otherwise `q` holds.

## Timing
- ALU: purely combinational, zero latency. No latches; every `alucontrol` value yields a defined result.
- `aluout` and `q`: one-cycle latency, rising edge.
- Reset: asserting `reset` immediately (asynchronously) forces `aluout = 0` and `q = 0`, independent of `clk` and `en`.
- While `reset` is high, registers stay 0.
- The first rising edge after deassertion loads normally (`q` loads only if `en = 1`).
- Reset asserted mid-operation discards the pending value; no partial state remains.
- `en` and `d` changing together before an edge: the value sampled at the edge wins.

## Structure
- Shared package `mc_alu_pkg` holds the ALU opcode constants: `ALU_AND=4'b0000`, `ALU_OR=4'b0001`, `ALU_ADD=4'b0010`, `ALU_SUB=4'b0110`, `ALU_SLT=4'b0111`, `ALU_SLTU=4'b1111`.
- Sub-modules `alu`, `flopr #(WIDTH)` and `flopenr #(WIDTH)` are each separately instantiable. The datapath instantiates them directly with `WIDTH=32`.
- The wrapper only wires:
  - `alu` → `flopr #(32)` (ALUOut)
  - `flopenr #(WIDTH)` (on `d`/`en`/`q`)

## Test plan
- ADD / wrap / SUB-zero:
  - `a=0x7FFFFFFF`, `b=1`, `0010` → `aluresult=0x80000000`, `zero=0`.
  - `a=0xFFFFFFFF`, `b=1` → `0`, `zero=1`.
  - SUB `a=5`, `b=5` → `0`, `zero=1`.
- Signed vs. unsigned compare:
  - SLT `a=0xFFFFFFFF`, `b=1` → `1`.
  - SLTU same operands → `0`.
  - SLT `a=0x80000000`, `b=0x7FFFFFFF` (overflow case) → `1`.
- Logic ops: `a=0xF0F0F0F0`, `b=0x0FF00FF0`:
  - AND → `0x00F000F0`.
  - OR → `0xFFF0FFF0`.
  - SUB `a=3`, `b=7` → `0xFFFFFFFC` (bit 31 set).
- ALUOut register: drive ADD `1+2`, clock → `aluout=3` one cycle later. Change operands → `aluout` updates only at the next edge.
- Enabled register: with `en=0`, `d=0x00400000`, clock → `q` holds. With `en=1`, clock → `q=0x00400000`. Then `en=0`, `d=0x1234`, clock → `q` is still `0x00400000`.
- Async reset: with `q` and `aluout` nonzero, pulse `reset` between clock edges → both read `0` before the next edge. Hold `reset` with `en=1` across an edge → `q` stays `0`.
